burst_sram_ctrl: RTL and testbench
==================================

Name: burst_sram_ctrl

Overview:
- Parametrised single-port synchronous SRAM with a burst command interface; one data beat per clock at full throughput.
- Per-beat valid/ready handshakes on write and read data, so producer and consumer backpressure are honoured.
- Supports incrementing bursts (wrap at top of memory) and aligned wrapping bursts.
- Serves as the generic local buffer memory for datapath blocks.

Parameters:
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- DATA_W, 8, data word width
- LEN_W, 5, burst length field width; maximum burst is 2**LEN_W-1 beats

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_we  in  1  1=write burst, 0=read burst
- cmd_wrap  in  1  1=wrapping burst, 0=incrementing burst
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  LEN_W  number of beats (0 is illegal)
- wdata_valid  in  1  write beat valid
- wdata_ready  out  1  high in WR state
- wdata  in  DATA_W  write data
- rdata_valid  out  1  read beat valid
- rdata_ready  in  1  read beat accept
- rdata  out  DATA_W  read data, registered
- rdata_perr  out  1  parity error on current rdata beat
- done  out  1  one-cycle pulse: burst completed
- err  out  1  one-cycle pulse: command rejected

Behaviour:
- Reset (async, immediate): state=IDLE; cmd_ready=1; wdata_ready=0; rdata_valid=0; rdata=0; rdata_perr=0; done=0; err=0; address and beat counters=0.
- Memory array is never reset; contents survive rst.
- States: IDLE, WR, RD, FIN.
- IDLE: a command is accepted when cmd_valid&&cmd_ready. Latch addr, len, wrap and we; set beat count=0.
  - Illegal command (cmd_len==0, or cmd_wrap=1 with cmd_len not in {2,4,8,16}): go to FIN with err=1 and no memory access.
  - Otherwise go to WR or RD.
- WR: on each wdata_valid&&wdata_ready, write mem[cur] = wdata and advance cur. After the final beat, go to FIN.
- RD: the output register loads mem[cur] when !rdata_valid || rdata_ready, then advances cur. Read latency is 1 cycle from state entry to first rdata_valid. rdata holds stable while rdata_valid&&!rdata_ready.
  - After the final beat is loaded, stop issuing reads.
  - Go to FIN once the final beat is handshaked.
- FIN: lasts one cycle with cmd_ready=0. done=1 for a legal burst; err=1 (done=0) for an illegal command. Then return to IDLE.
- Address advance:
  - Incrementing: cur = cur+1 mod DEPTH; wraps from DEPTH-1 to 0.
  - Wrapping: upper bits are fixed at start_addr & ~(len-1); low log2(len) bits increment mod len.
  - Example: len=4, addr=6 gives 6,7,4,5.
- Beat counter is LEN_W wide and compares against len-1; no overflow at maximum length.
- Simultaneous events: cmd_valid during WR/RD/FIN is ignored (cmd_ready=0). In FIN, wdata_valid is ignored.
- Reset asserted mid-burst aborts the burst; beats already written remain in memory. No done pulse is produced.

Optional Feature:
- BURST_SRAM_PARITY_EN defined:
  - Each word stores an extra even-parity bit, computed from wdata on write.
  - On read, rdata_perr = stored parity XOR ^rdata, registered with rdata.
- Undefined: no parity storage; rdata_perr is tied 0.

Decomposition:
- Package burst_sram_pkg holds the state encoding (IDLE, WR, RD, FIN) and a helper function wrap_len_ok(len) for the legal-wrap-length check.
- One sub-module: burst_addr_gen. It takes start address, len and wrap, and produces cur on an advance strobe, plus a last flag.
- Memory array and FSM live in the top.

Test Plan:
- Write burst addr=3 len=4 incr, data 0xA0..0xA3 with continuous valid; then read addr=3 len=4 with rdata_ready=1. Required: rdata 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; one done pulse per burst.
- Incr write addr=14 len=4, then read addr=0 len=2. Required: mem[14],mem[15],mem[0],mem[1] written, confirming wrap at top of memory.
- Wrap read len=4 addr=6 after filling mem[i]=i. Required: rdata order 6,7,4,5.
- cmd_len=0, and cmd_wrap=1 with len=3. Required: err pulse, no done, memory unchanged, cmd_ready back high 2 cycles after acceptance.
- Read len=3 with rdata_ready toggled 1,0,0,1,1. Required: rdata held stable while stalled; exactly 3 handshakes; done after the last one.
- rst asserted at beat 2 of a 5-beat write. Required: outputs return to reset values immediately; mem[addr], mem[addr+1] hold new data; with BURST_SRAM_PARITY_EN, a forced corrupt parity bit gives rdata_perr=1 on that beat.

Source files
------------

// File: rtl/burst_sram_pkg.sv
// Shared definitions for the burst SRAM controller: FSM state encoding and
// the legality check for wrapping burst lengths.
package burst_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // Wrapping bursts must cover a power-of-two window so the low address
  // bits can simply roll over inside an aligned block.
  function automatic logic wrap_len_ok(input logic [31:0] len);
    return (len == 32'd2) || (len == 32'd4) || (len == 32'd8) || (len == 32'd16);
  endfunction

endpackage

// File: rtl/burst_sram_ctrl_if.sv
// Bus bundle for burst_sram_ctrl: command channel, write-data channel,
// read-data channel and the completion/error pulses.
interface burst_sram_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
) ();
  import burst_sram_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic              cmd_wrap;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;

  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_perr;

  logic              done;
  logic              err;

  // The block that issues bursts and moves the data.
  modport master (
    output cmd_valid, cmd_we, cmd_wrap, cmd_addr, cmd_len,
    output wdata_valid, wdata, rdata_ready,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, rdata_perr, done, err
  );

  // The memory controller itself.
  modport slave (
    input  cmd_valid, cmd_we, cmd_wrap, cmd_addr, cmd_len,
    input  wdata_valid, wdata, rdata_ready,
    output cmd_ready, wdata_ready, rdata_valid, rdata, rdata_perr, done, err
  );

endinterface

// File: rtl/burst_addr_gen.sv
// Burst address generator: holds the current word address and beat count of
// the active burst. Incrementing bursts roll over at the top of memory;
// wrapping bursts keep the upper address bits fixed and roll the low bits.
module burst_addr_gen
  import burst_sram_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              wrap_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] cur_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] cur_q,     cur_d;
  logic [ADDR_W-1:0] mask_q,    mask_d;
  logic [LEN_W-1:0]  cnt_q,     cnt_d;
  logic [LEN_W-1:0]  lastIdx_q, lastIdx_d;
  logic [ADDR_W-1:0] curInc;

  // The mask selects the address bits allowed to count. An incrementing burst
  // lets every bit count (natural roll-over at DEPTH); a wrapping burst only
  // lets the low log2(len) bits count, so the rest stay at start & ~(len-1).
  always_comb begin
    cur_d     = cur_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    lastIdx_d = lastIdx_q;
    curInc    = cur_q + ADDR_W'(1);
    if (load_i) begin
      cur_d     = start_addr_i;
      mask_d    = wrap_i ? ADDR_W'(len_i - LEN_W'(1)) : '1;
      cnt_d     = '0;
      lastIdx_d = len_i - LEN_W'(1);
    end else if (adv_i) begin
      cur_d = (cur_q & ~mask_q) | (curInc & mask_q);
      cnt_d = cnt_q + LEN_W'(1);
    end
  end

  // Burst bookkeeping registers, cleared by reset so an aborted burst leaves
  // no stale position behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q     <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      lastIdx_q <= '0;
    end else begin
      cur_q     <= cur_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      lastIdx_q <= lastIdx_d;
    end
  end

  // Comparing against len-1 rather than len keeps the count within LEN_W
  // bits even for the longest burst.
  assign cur_o  = cur_q;
  assign last_o = (cnt_q == lastIdx_q);

endmodule

// File: rtl/burst_sram_ctrl.sv
// burst_sram_ctrl: single-port synchronous SRAM behind a burst command
// interface, one beat per clock with per-beat valid/ready on both data paths.
// Optional build macro BURST_SRAM_PARITY_EN adds an even-parity bit per word
// and reports mismatches on rdata_perr alongside the read data.
module burst_sram_ctrl
  import burst_sram_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
) (
  input  logic           clk,
  input  logic           rst,
  burst_sram_ctrl_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef BURST_SRAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_e            state_q, state_d;
  logic              bad_q, bad_d;
  logic              loadedAll_q, loadedAll_d;
  logic              rdValid_q, rdValid_d;
  logic [DATA_W-1:0] rdata_q;

  logic              cmdAccept;
  logic              cmdIllegal;
  logic              wrBeat;
  logic              rdLoad;
  logic [ADDR_W-1:0] agCur;
  logic              agLast;

  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic [MEM_W-1:0]  memWord;
  logic [MEM_W-1:0]  writeWord;

  burst_addr_gen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .load_i      (cmdAccept),
    .start_addr_i(bus.cmd_addr),
    .len_i       (bus.cmd_len),
    .wrap_i      (bus.cmd_wrap),
    .adv_i       (wrBeat | rdLoad),
    .cur_o       (agCur),
    .last_o      (agLast)
  );

  // A zero-length burst, or a wrapping burst whose length is not a supported
  // power of two, is rejected without touching memory.
  assign cmdIllegal = (bus.cmd_len == '0) ||
                      (bus.cmd_wrap && !wrap_len_ok(32'(bus.cmd_len)));

  // Next-state logic. Reads prefetch into the output register whenever it is
  // empty or being drained, stop once the final beat has been loaded, and the
  // burst ends when that final beat is handshaked.
  always_comb begin
    state_d     = state_q;
    bad_d       = bad_q;
    loadedAll_d = loadedAll_q;
    rdValid_d   = rdValid_q;
    cmdAccept   = 1'b0;
    wrBeat      = 1'b0;
    rdLoad      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          cmdAccept   = 1'b1;
          loadedAll_d = 1'b0;
          bad_d       = cmdIllegal;
          if (cmdIllegal) begin
            state_d = ST_FIN;
          end else if (bus.cmd_we) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_WR: begin
        if (bus.wdata_valid) begin
          wrBeat = 1'b1;
          if (agLast) begin
            state_d = ST_FIN;
          end
        end
      end
      ST_RD: begin
        rdLoad = !loadedAll_q && (!rdValid_q || bus.rdata_ready);
        if (rdLoad) begin
          rdValid_d = 1'b1;
          if (agLast) begin
            loadedAll_d = 1'b1;
          end
        end else if (rdValid_q && bus.rdata_ready) begin
          rdValid_d = 1'b0;
        end
        if (loadedAll_q && rdValid_q && bus.rdata_ready) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state; reset drops any burst in flight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bad_q       <= 1'b0;
      loadedAll_q <= 1'b0;
      rdValid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bad_q       <= bad_d;
      loadedAll_q <= loadedAll_d;
      rdValid_q   <= rdValid_d;
    end
  end

`ifdef BURST_SRAM_PARITY_EN
  assign writeWord = {^bus.wdata, bus.wdata};
`else
  assign writeWord = bus.wdata;
`endif

  assign memWord = mem_q[agCur];

  // Storage array: written one beat per accepted write handshake. It has no
  // reset so contents survive rst and the array can map onto real SRAM.
  always_ff @(posedge clk) begin
    if (wrBeat) begin
      mem_q[agCur] <= writeWord;
    end
  end

  // Registered read data; only reloaded on a prefetch so a stalled beat
  // holds steady until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rdLoad) begin
      rdata_q <= memWord[DATA_W-1:0];
    end
  end

`ifdef BURST_SRAM_PARITY_EN
  logic perr_q;

  // Parity check travels with the data word it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else if (rdLoad) begin
      perr_q <= memWord[DATA_W] ^ (^memWord[DATA_W-1:0]);
    end
  end

  assign bus.rdata_perr = perr_q;
`else
  assign bus.rdata_perr = 1'b0;
`endif

  assign bus.cmd_ready   = (state_q == ST_IDLE);
  assign bus.wdata_ready = (state_q == ST_WR);
  assign bus.rdata_valid = rdValid_q;
  assign bus.rdata       = rdata_q;
  assign bus.done        = (state_q == ST_FIN) && !bad_q;
  assign bus.err         = (state_q == ST_FIN) && bad_q;

endmodule

// File: tb/tb_burst_sram_ctrl.sv
// Self-checking bench for burst_sram_ctrl. A word-level memory model and a
// burst address formula predict every read beat; a command table covers the
// basic scenarios, hand sequences cover stalls, reset abort and wrap order,
// and a randomized phase mixes legal and illegal bursts with backpressure.
// Build with BURST_SRAM_PARITY_EN to also exercise the parity error path.
`timescale 1ns/1ps
module tb_burst_sram_ctrl;
  import burst_sram_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 5;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int BUDGET = 200;

  logic clk = 1'b0;
  logic rst;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [DATA_W-1:0] refMem [DEPTH];
  logic [DATA_W-1:0] wbuf   [32];
  logic [DATA_W-1:0] obs    [32];

  typedef struct {
    bit                we;
    bit                wrap;
    int                addr;
    int                len;
    logic [DATA_W-1:0] dataBase;
    bit                expErr;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  burst_sram_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  burst_sram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Address of beat i of a burst, straight from the burst rules.
  function automatic int addrOf(input int addr, input int len, input bit wrap, input int i);
    int base;
    if (wrap) begin
      base = addr - (addr % len);
      return base + ((addr % len + i) % len);
    end
    return (addr + i) % DEPTH;
  endfunction

  function automatic bit isLegal(input int len, input bit wrap);
    if (len == 0) return 1'b0;
    if (wrap && !(len == 2 || len == 4 || len == 8 || len == 16)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Runs one complete burst from IDLE back to IDLE, checking every cycle.
  // validMode: 0 continuous, 1 random. readyMode: 0 always, 1 random, 2 pattern.
  task automatic applyStimulus(input bit we, input bit wrap, input int addr, input int len,
                               input bit expIllegal, input int validMode, input int readyMode,
                               input logic [15:0] readyPat, input int patLen, input bit expPerr);
    int beats;
    int cycles;
    int patIdx;
    bit v;
    bit r;
    bit stalled;
    logic [DATA_W-1:0] heldVal;

    @(negedge clk);
    checkOutput("idle_cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_wrap  = wrap;
    bus.cmd_addr  = ADDR_W'(addr);
    bus.cmd_len   = LEN_W'(len);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput("busy_cmd_ready", bus.cmd_ready, 0);

    if (expIllegal) begin
      checkOutput("illegal_err", bus.err, 1);
      checkOutput("illegal_done", bus.done, 0);
      checkOutput("illegal_wready", bus.wdata_ready, 0);
      @(negedge clk);
      checkOutput("illegal_ready_back", bus.cmd_ready, 1);
      checkOutput("illegal_err_end", bus.err, 0);
      return;
    end

    beats   = 0;
    cycles  = 0;
    patIdx  = 0;
    stalled = 1'b0;
    heldVal = '0;

    if (we) begin
      while (beats < len && cycles < BUDGET) begin
        checkOutput("wr_ready", bus.wdata_ready, 1);
        checkOutput("wr_cmd_ready", bus.cmd_ready, 0);
        v = (validMode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        bus.wdata_valid = v;
        bus.wdata       = wbuf[beats];
        bus.cmd_valid   = 1'($urandom_range(0, 1));
        @(negedge clk);
        cycles++;
        if (v) begin
          refMem[addrOf(addr, len, wrap, beats)] = wbuf[beats];
          beats++;
        end
      end
      checkOutput("wr_beats", beats, len);
      // A stray beat offered during FIN must not reach memory.
      bus.wdata_valid = 1'b1;
      bus.wdata       = 8'hEE;
    end else begin
      while (beats < len && cycles < BUDGET) begin
        checkOutput("rd_cmd_ready", bus.cmd_ready, 0);
        checkOutput("rd_wready", bus.wdata_ready, 0);
        checkOutput("rd_valid", bus.rdata_valid, (cycles >= 1) ? 1 : 0);
        bus.cmd_valid = 1'($urandom_range(0, 1));
        if (bus.rdata_valid) begin
          if (stalled) checkOutput("rd_hold", bus.rdata, heldVal);
          checkOutput("rd_data", bus.rdata, refMem[addrOf(addr, len, wrap, beats)]);
          checkOutput("rd_perr", bus.rdata_perr, expPerr);
          case (readyMode)
            0:       r = 1'b1;
            1:       r = 1'($urandom_range(0, 1));
            default: r = (patIdx < patLen) ? readyPat[patIdx] : 1'b1;
          endcase
          patIdx++;
          stalled     = !r;
          heldVal     = bus.rdata;
          obs[beats]  = bus.rdata;
          bus.rdata_ready = r;
          if (r) beats++;
        end else begin
          bus.rdata_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        cycles++;
      end
      checkOutput("rd_beats", beats, len);
      bus.rdata_ready = 1'b0;
    end

    bus.cmd_valid = 1'b0;
    checkOutput("fin_done", bus.done, 1);
    checkOutput("fin_err", bus.err, 0);
    checkOutput("fin_cmd_ready", bus.cmd_ready, 0);
    checkOutput("fin_wready", bus.wdata_ready, 0);
    checkOutput("fin_rvalid", bus.rdata_valid, 0);
    @(negedge clk);
    bus.wdata_valid = 1'b0;
    checkOutput("done_pulse_end", bus.done, 0);
    checkOutput("back_idle", bus.cmd_ready, 1);
  endtask

  // Hard stop in case the bench itself loses its way.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rl;
    bit rw;
    bit rwe;

    bus.cmd_valid   = 1'b0;
    bus.cmd_we      = 1'b0;
    bus.cmd_wrap    = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_len     = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    bus.rdata_ready = 1'b0;
    rst = 1'b1;

    // Command table; reads are predicted from the memory model.
    vecs[0] = '{1'b1, 1'b0,  3, 4, 8'hA0, 1'b0};
    vecs[1] = '{1'b0, 1'b0,  3, 4, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 14, 4, 8'hC0, 1'b0};
    vecs[3] = '{1'b0, 1'b0,  0, 2, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 14, 2, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 1'b0,  3, 0, 8'h11, 1'b1};
    vecs[6] = '{1'b1, 1'b1,  3, 3, 8'h22, 1'b1};
    vecs[7] = '{1'b0, 1'b0,  3, 4, 8'h00, 1'b0};

    repeat (2) @(negedge clk);
    checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
    checkOutput("rst_wready", bus.wdata_ready, 0);
    checkOutput("rst_rvalid", bus.rdata_valid, 0);
    checkOutput("rst_rdata", bus.rdata, 0);
    checkOutput("rst_perr", bus.rdata_perr, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_err", bus.err, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < 32; b++) wbuf[b] = vecs[i].dataBase + DATA_W'(b);
      applyStimulus(vecs[i].we, vecs[i].wrap, vecs[i].addr, vecs[i].len, vecs[i].expErr,
                    0, 0, 16'h0, 0, 1'b0);
    end
    // Last table read revisits addr 3 after the rejected commands.
    for (int i = 0; i < 4; i++) checkOutput("plan_incr_data", obs[i], 32'hA0 + i);

    // Fill memory with mem[i] = i using bursty write valid.
    for (int b = 0; b < 32; b++) wbuf[b] = DATA_W'(b);
    applyStimulus(1'b1, 1'b0, 0, 16, 1'b0, 1, 0, 16'h0, 0, 1'b0);

    // Wrapping read inside an aligned 4-word block.
    applyStimulus(1'b0, 1'b1, 6, 4, 1'b0, 0, 0, 16'h0, 0, 1'b0);
    checkOutput("wrap_order0", obs[0], 6);
    checkOutput("wrap_order1", obs[1], 7);
    checkOutput("wrap_order2", obs[2], 4);
    checkOutput("wrap_order3", obs[3], 5);

    // Consumer stalls with ready sequence 1,0,0,1,1 on a 3-beat read.
    applyStimulus(1'b0, 1'b0, 1, 3, 1'b0, 0, 2, 16'h0019, 5, 1'b0);

    // Reset during beat 2 of a 5-beat write at address 9.
    for (int b = 0; b < 5; b++) wbuf[b] = 8'h50 + DATA_W'(b);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_wrap  = 1'b0;
    bus.cmd_addr  = 4'd9;
    bus.cmd_len   = 5'd5;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.wdata_valid = 1'b1;
      bus.wdata       = wbuf[i];
      @(negedge clk);
      refMem[9 + i] = wbuf[i];
    end
    bus.wdata = wbuf[2];
    rst = 1'b1;
    #1;
    checkOutput("abort_cmd_ready", bus.cmd_ready, 1);
    checkOutput("abort_wready", bus.wdata_ready, 0);
    checkOutput("abort_rvalid", bus.rdata_valid, 0);
    checkOutput("abort_rdata", bus.rdata, 0);
    checkOutput("abort_perr", bus.rdata_perr, 0);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_err", bus.err, 0);
    @(negedge clk);
    checkOutput("abort_no_done", bus.done, 0);
    rst = 1'b0;
    bus.wdata_valid = 1'b0;
    applyStimulus(1'b0, 1'b0, 9, 3, 1'b0, 0, 0, 16'h0, 0, 1'b0);
    checkOutput("abort_kept0", obs[0], 8'h50);
    checkOutput("abort_kept1", obs[1], 8'h51);
    checkOutput("abort_untouched", obs[2], 11);

`ifdef BURST_SRAM_PARITY_EN
    dut.mem_q[5][DATA_W] = ~dut.mem_q[5][DATA_W];
    applyStimulus(1'b0, 1'b0, 5, 1, 1'b0, 0, 0, 16'h0, 0, 1'b1);
    dut.mem_q[5][DATA_W] = ~dut.mem_q[5][DATA_W];
    applyStimulus(1'b0, 1'b0, 5, 1, 1'b0, 0, 0, 16'h0, 0, 1'b0);
`endif

    // Randomized bursts with backpressure on both sides.
    for (int n = 0; n < 40; n++) begin
      rwe = 1'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      if (rw) begin
        case ($urandom_range(0, 9))
          0, 4:    rl = 2;
          1, 5:    rl = 4;
          2, 6:    rl = 8;
          3, 7:    rl = 16;
          8:       rl = 3;
          default: rl = 0;
        endcase
      end else begin
        rl = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
      end
      for (int b = 0; b < 32; b++) wbuf[b] = DATA_W'($urandom_range(0, 255));
      applyStimulus(rwe, rw, int'($urandom_range(0, DEPTH - 1)), rl, !isLegal(rl, rw),
                    1, 1, 16'h0, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
